// File: rtl/npu_launch_ctrl.sv
// npu_launch_ctrl: launches one NPU operation per CPU request and arbitrates the
// shared data-memory port between the CPU and the NPU.
// Optional feature: define NPU_LAUNCH_PERF_EN to enable the RUN-cycle counter on
// o_perf_cycles; otherwise o_perf_cycles is tied to zero.
module npu_launch_ctrl #(
    parameter int unsigned SETUP_CYC = 3,
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned DW        = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cpu_en_npu,
    input  logic [9:0]    i_mat_a,
    input  logic [9:0]    i_mat_b,
    input  logic [9:0]    i_mat_c,
    input  logic          i_npu_ack,
    input  logic          i_cpu_mem_rd,
    input  logic          i_cpu_mem_wr,
    input  logic [DW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wd,
    input  logic          i_npu_mem_rd,
    input  logic          i_npu_mem_wr,
    input  logic [DW-1:0] i_npu_addr,
    input  logic [DW-1:0] i_npu_wd,
    output logic          o_mem_rd,
    output logic          o_mem_wr,
    output logic [DW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wd,
    output logic          o_npu_en,
    output logic [7:0]    o_src1_addr,
    output logic [7:0]    o_src2_addr,
    output logic [7:0]    o_rd_addr,
    output logic          o_cpu_stall,
    output logic          o_cpu_done,
    output logic          o_busy,
    output logic          o_timeout_err,
    output logic [15:0]   o_perf_cycles
);

    localparam int unsigned CNT_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETUP_CYC - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StRun,
        StDone,
        StRelease
    } state_t;

    state_t           r_state, w_state_d;
    logic             r_req_q;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [WD_W-1:0]  r_wd, w_wd_d;
    logic             r_npu_en, w_npu_en_d;
    logic             r_owner_npu, w_owner_npu_d;
    logic             r_cpu_done, w_cpu_done_d;
    logic             r_timeout_err, w_timeout_err_d;
    logic [7:0]       r_src1, w_src1_d;
    logic [7:0]       r_src2, w_src2_d;
    logic [7:0]       r_rd, w_rd_d;

    // Byte-offset bits of the matrix addresses are not needed for word addressing.
    logic w_unused_bits;
    assign w_unused_bits = ^{i_mat_a[1:0], i_mat_b[1:0], i_mat_c[1:0]};

    // State register and all registered outputs; reset aborts immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            // A level already high when reset releases is stale and must not launch.
            r_req_q       <= 1'b1;
            r_cnt         <= '0;
            r_wd          <= '0;
            r_npu_en      <= 1'b0;
            r_owner_npu   <= 1'b0;
            r_cpu_done    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_src1        <= '0;
            r_src2        <= '0;
            r_rd          <= '0;
        end else begin
            r_state       <= w_state_d;
            r_req_q       <= i_cpu_en_npu;
            r_cnt         <= w_cnt_d;
            r_wd          <= w_wd_d;
            r_npu_en      <= w_npu_en_d;
            r_owner_npu   <= w_owner_npu_d;
            r_cpu_done    <= w_cpu_done_d;
            r_timeout_err <= w_timeout_err_d;
            r_src1        <= w_src1_d;
            r_src2        <= w_src2_d;
            r_rd          <= w_rd_d;
        end
    end

    // Next-state logic: setup delay, run with watchdog, done pulse, release handshake.
    always_comb begin
        w_state_d       = r_state;
        w_cnt_d         = r_cnt;
        w_wd_d          = r_wd;
        w_npu_en_d      = 1'b0;
        w_owner_npu_d   = 1'b0;
        w_cpu_done_d    = 1'b0;
        w_timeout_err_d = r_timeout_err;
        w_src1_d        = r_src1;
        w_src2_d        = r_src2;
        w_rd_d          = r_rd;
        case (r_state)
            StIdle: begin
                if (i_cpu_en_npu && !r_req_q) begin
                    w_src1_d        = i_mat_a[9:2];
                    w_src2_d        = i_mat_b[9:2];
                    w_rd_d          = i_mat_c[9:2];
                    w_cnt_d         = CNT_INIT;
                    w_timeout_err_d = 1'b0;
                    w_state_d       = StSetup;
                end
            end
            StSetup: begin
                if (!i_cpu_en_npu) begin
                    w_state_d = StIdle;
                end else if (r_cnt == '0) begin
                    w_state_d     = StRun;
                    w_npu_en_d    = 1'b1;
                    w_owner_npu_d = 1'b1;
                    w_wd_d        = '0;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StRun: begin
                // Ack takes priority over a coincident watchdog expiry.
                if (i_npu_ack) begin
                    w_state_d    = StDone;
                    w_cpu_done_d = 1'b1;
                end else if (r_wd == WD_LAST) begin
                    w_state_d       = StDone;
                    w_cpu_done_d    = 1'b1;
                    w_timeout_err_d = 1'b1;
                end else begin
                    w_npu_en_d    = 1'b1;
                    w_owner_npu_d = 1'b1;
                    w_wd_d        = r_wd + 1'b1;
                end
            end
            StDone: begin
                w_state_d = StRelease;
            end
            StRelease: begin
                if (!i_cpu_en_npu) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Memory port mux and CPU hazard; the non-owner never reaches memory.
    always_comb begin
        o_mem_rd    = i_cpu_mem_rd;
        o_mem_wr    = i_cpu_mem_wr;
        o_mem_addr  = i_cpu_addr;
        o_mem_wd    = i_cpu_wd;
        o_cpu_stall = 1'b0;
        if (r_owner_npu) begin
            o_mem_rd    = i_npu_mem_rd;
            o_mem_wr    = i_npu_mem_wr;
            o_mem_addr  = i_npu_addr;
            o_mem_wd    = i_npu_wd;
            o_cpu_stall = i_cpu_mem_rd | i_cpu_mem_wr;
        end
    end

    assign o_npu_en      = r_npu_en;
    assign o_src1_addr   = r_src1;
    assign o_src2_addr   = r_src2;
    assign o_rd_addr     = r_rd;
    assign o_cpu_done    = r_cpu_done;
    assign o_busy        = (r_state != StIdle);
    assign o_timeout_err = r_timeout_err;

`ifdef NPU_LAUNCH_PERF_EN
    logic [15:0] r_perf_cnt;
    logic [15:0] r_perf_cycles;

    // Counts RUN cycles (zero outside RUN, so it starts clean on RUN entry) and
    // publishes the total, including the final RUN cycle, on DONE entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_cnt    <= '0;
            r_perf_cycles <= '0;
        end else begin
            if (r_state != StRun) begin
                r_perf_cnt <= '0;
            end else if (r_perf_cnt != 16'hFFFF) begin
                r_perf_cnt <= r_perf_cnt + 16'd1;
            end
            if (r_state == StRun && w_state_d == StDone) begin
                r_perf_cycles <= (r_perf_cnt == 16'hFFFF) ? 16'hFFFF : r_perf_cnt + 16'd1;
            end
        end
    end

    assign o_perf_cycles = r_perf_cycles;
`else
    assign o_perf_cycles = '0;
`endif

endmodule

// File: tb/tb_npu_launch_ctrl.sv
// Self-checking bench for npu_launch_ctrl: mux vector table, directed launch
// sequences, reset abort, and randomized operations checked against a
// timeline model of one operation.
module tb_npu_launch_ctrl;

    localparam int unsigned SETUP_CYC = 3;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned DW        = 32;
`ifdef NPU_LAUNCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk, rst, en, ack;
    logic [9:0]    mat_a, mat_b, mat_c;
    logic          cpu_rd, cpu_wr, npu_rd, npu_wr;
    logic [DW-1:0] cpu_addr, cpu_wd, npu_addr, npu_wd;
    logic          mem_rd, mem_wr, npu_en, cpu_stall, cpu_done, busy, timeout_err;
    logic [DW-1:0] mem_addr, mem_wd;
    logic [7:0]    src1, src2, rdad;
    logic [15:0]   perf;

    int n_err;
    int n_checks;

    // Model state that outlives a single operation.
    logic [7:0]  exp_src1, exp_src2, exp_rd;
    logic        exp_terr;
    logic [15:0] exp_perf;

    npu_launch_ctrl #(
        .SETUP_CYC(SETUP_CYC),
        .TIMEOUT  (TIMEOUT),
        .DW       (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cpu_en_npu (en),
        .i_mat_a      (mat_a),
        .i_mat_b      (mat_b),
        .i_mat_c      (mat_c),
        .i_npu_ack    (ack),
        .i_cpu_mem_rd (cpu_rd),
        .i_cpu_mem_wr (cpu_wr),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wd     (cpu_wd),
        .i_npu_mem_rd (npu_rd),
        .i_npu_mem_wr (npu_wr),
        .i_npu_addr   (npu_addr),
        .i_npu_wd     (npu_wd),
        .o_mem_rd     (mem_rd),
        .o_mem_wr     (mem_wr),
        .o_mem_addr   (mem_addr),
        .o_mem_wd     (mem_wd),
        .o_npu_en     (npu_en),
        .o_src1_addr  (src1),
        .o_src2_addr  (src2),
        .o_rd_addr    (rdad),
        .o_cpu_stall  (cpu_stall),
        .o_cpu_done   (cpu_done),
        .o_busy       (busy),
        .o_timeout_err(timeout_err),
        .o_perf_cycles(perf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        own_npu;
        logic        crd, cwr;
        logic [31:0] caddr, cwd;
        logic        nrd, nwr;
        logic [31:0] naddr, nwd;
        logic        erd, ewr;
        logic [31:0] eaddr, ewd;
        logic        estall;
    } vec_t;

    localparam int NV = 7;
    localparam int V_PLAN = 3;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are driven just after the falling edge, outputs sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic mem_rand();
        cpu_rd   = 1'($urandom);
        cpu_wr   = 1'($urandom);
        npu_rd   = 1'($urandom);
        npu_wr   = 1'($urandom);
        cpu_addr = $urandom;
        cpu_wd   = $urandom;
        npu_addr = $urandom;
        npu_wd   = $urandom;
    endtask

    task automatic mux_chk(input logic own);
        chk("mem_rd",   32'(own ? npu_rd : cpu_rd), 32'(mem_rd));
        chk("mem_wr",   32'(own ? npu_wr : cpu_wr), 32'(mem_wr));
        chk("mem_addr", own ? npu_addr : cpu_addr, mem_addr);
        chk("mem_wd",   own ? npu_wd : cpu_wd, mem_wd);
        chk("cpu_stall", 32'(own & (cpu_rd | cpu_wr)), 32'(cpu_stall));
    endtask

    task automatic apply_vec(input vec_t v);
        cpu_rd = v.crd; cpu_wr = v.cwr; cpu_addr = v.caddr; cpu_wd = v.cwd;
        npu_rd = v.nrd; npu_wr = v.nwr; npu_addr = v.naddr; npu_wd = v.nwd;
    endtask

    task automatic chk_vec(input vec_t v);
        chk("vec_mem_rd", 32'(mem_rd), 32'(v.erd));
        chk("vec_mem_wr", 32'(mem_wr), 32'(v.ewr));
        chk("vec_mem_addr", mem_addr, v.eaddr);
        chk("vec_mem_wd", mem_wd, v.ewd);
        chk("vec_cpu_stall", 32'(cpu_stall), 32'(v.estall));
    endtask

    task automatic chk_regs();
        chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
        chk("perf_cycles", 32'(perf), 32'(exp_perf));
        chk("src1_addr", 32'(src1), 32'(exp_src1));
        chk("src2_addr", 32'(src2), 32'(exp_src2));
        chk("rd_addr", 32'(rdad), 32'(exp_rd));
    endtask

    // One operation from IDLE. abort_win: SETUP window (1..SETUP_CYC) in which the
    // request drops, 0 for none. ack_win: RUN cycle (1..TIMEOUT) carrying the ack,
    // 0 for none (watchdog completes it after TIMEOUT RUN cycles).
    task automatic do_op(input int abort_win, input int ack_win, input logic [9:0] a,
                         input logic [9:0] b, input logic [9:0] c);
        int   n_run;
        logic exp_t;
        int   hold;
        step();
        en = 1'b1; mat_a = a; mat_b = b; mat_c = c; ack = 1'($urandom); mem_rand();
        #1;
        chk("op_idle_busy", 32'(busy), 0);
        mux_chk(1'b0);
        exp_src1 = a[9:2]; exp_src2 = b[9:2]; exp_rd = c[9:2]; exp_terr = 1'b0;
        for (int w = 1; w <= int'(SETUP_CYC); w++) begin
            step();
            if (w == abort_win) en = 1'b0;
            mat_a = 10'($urandom); mat_b = 10'($urandom); mat_c = 10'($urandom);
            ack = 1'($urandom); mem_rand();
            #1;
            chk("setup_npu_en", 32'(npu_en), 0);
            chk("setup_busy", 32'(busy), 1);
            chk("setup_done", 32'(cpu_done), 0);
            chk_regs();
            mux_chk(1'b0);
            if (w == abort_win) begin
                step();
                ack = 1'($urandom); mem_rand();
                #1;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_npu_en", 32'(npu_en), 0);
                chk("abort_done", 32'(cpu_done), 0);
                chk_regs();
                mux_chk(1'b0);
                return;
            end
        end
        n_run = (ack_win == 0) ? int'(TIMEOUT) : ack_win;
        exp_t = (ack_win == 0);
        for (int r = 1; r <= n_run; r++) begin
            step();
            en = 1'($urandom); ack = (r == ack_win); mem_rand();
            #1;
            chk("run_npu_en", 32'(npu_en), 1);
            chk("run_busy", 32'(busy), 1);
            chk("run_done", 32'(cpu_done), 0);
            chk_regs();
            mux_chk(1'b1);
        end
        exp_terr = exp_t;
        exp_perf = PERF ? 16'(n_run) : 16'd0;
        step();
        en = 1'b1; ack = 1'($urandom); mem_rand();
        #1;
        chk("done_pulse", 32'(cpu_done), 1);
        chk("done_npu_en", 32'(npu_en), 0);
        chk("done_busy", 32'(busy), 1);
        chk_regs();
        mux_chk(1'b0);
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) begin
            step();
            ack = 1'($urandom); mem_rand();
            #1;
            chk("rel_busy", 32'(busy), 1);
            chk("rel_done", 32'(cpu_done), 0);
            chk("rel_npu_en", 32'(npu_en), 0);
            mux_chk(1'b0);
        end
        step();
        en = 1'b0;
        #1;
        chk("rel_busy_drop", 32'(busy), 1);
        step();
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(cpu_done), 0);
        chk_regs();
    endtask

    initial begin
        int rw;
        n_err = 0; n_checks = 0;
        //            own crd cwr caddr   cwd     nrd nwr naddr   nwd     erd ewr eaddr   ewd     stall
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h100, 32'hAA, 1'b1, 1'b0, 32'h200, 32'h55,
                    1'b0, 1'b1, 32'h100, 32'hAA, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h104, 32'h0,  1'b0, 1'b1, 32'h204, 32'h77,
                    1'b1, 1'b0, 32'h104, 32'h0,  1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h108, 32'h1,  1'b1, 1'b1, 32'h208, 32'h2,
                    1'b0, 1'b0, 32'h108, 32'h1,  1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h100, 32'hAA, 1'b1, 1'b0, 32'h200, 32'h55,
                    1'b1, 1'b0, 32'h200, 32'h55, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h0,  1'b0, 1'b1, 32'h204, 32'h77,
                    1'b0, 1'b1, 32'h204, 32'h77, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h108, 32'h9,  1'b1, 1'b0, 32'h208, 32'h3,
                    1'b1, 1'b0, 32'h208, 32'h3,  1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10C, 32'h4,  1'b0, 1'b0, 32'h20C, 32'h5,
                    1'b0, 1'b0, 32'h20C, 32'h5,  1'b1};

        // Reset state.
        rst = 1'b1; en = 1'b0; ack = 1'b0; mat_a = '0; mat_b = '0; mat_c = '0;
        apply_vec(vecs[0]);
        exp_src1 = '0; exp_src2 = '0; exp_rd = '0; exp_terr = 1'b0; exp_perf = '0;
        step(); step();
        #1;
        chk("rst_npu_en", 32'(npu_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(cpu_done), 0);
        chk_regs();
        chk_vec(vecs[0]);
        step();
        rst = 1'b0;

        // Mux table with CPU as owner (IDLE).
        for (int i = 0; i < NV; i++) begin
            if (!vecs[i].own_npu) begin
                step(); apply_vec(vecs[i]); #1; chk_vec(vecs[i]);
            end
        end

        // Directed launch: addresses, setup latency, NPU-owner table, ack after 10.
        step();
        en = 1'b1; mat_a = 10'h010; mat_b = 10'h020; mat_c = 10'h030;
        #1;
        chk("plan_idle_busy", 32'(busy), 0);
        for (int w = 1; w <= int'(SETUP_CYC); w++) begin
            step(); #1;
            chk("plan_setup_npu_en", 32'(npu_en), 0);
            chk("plan_setup_busy", 32'(busy), 1);
        end
        step(); #1;
        rw = 1;
        chk("plan_npu_en_rise", 32'(npu_en), 1);
        chk("plan_src1", 32'(src1), 32'h04);
        chk("plan_src2", 32'(src2), 32'h08);
        chk("plan_rd", 32'(rdad), 32'h0C);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].own_npu) begin
                step(); rw++; apply_vec(vecs[i]); #1; chk_vec(vecs[i]);
            end
        end
        while (rw < 10) begin
            step(); rw++;
            apply_vec(vecs[V_PLAN]); ack = (rw == 10);
            #1;
            chk("plan_run_npu_en", 32'(npu_en), 1);
            chk_vec(vecs[V_PLAN]);
        end
        step(); ack = 1'b0; #1;
        chk("plan_done", 32'(cpu_done), 1);
        chk("plan_done_npu_en", 32'(npu_en), 0);
        chk("plan_done_busy", 32'(busy), 1);
        chk("plan_done_mem_addr", mem_addr, 32'h100);
        chk("plan_done_mem_wr", 32'(mem_wr), 1);
        chk("plan_done_stall", 32'(cpu_stall), 0);
        chk("plan_done_terr", 32'(timeout_err), 0);
        chk("plan_perf", 32'(perf), PERF ? 32'd10 : 32'd0);
        step(); #1;
        chk("plan_rel_done", 32'(cpu_done), 0);
        chk("plan_rel_busy", 32'(busy), 1);
        step(); en = 1'b0; #1;
        chk("plan_rel_busy2", 32'(busy), 1);
        step(); #1;
        chk("plan_idle", 32'(busy), 0);
        exp_src1 = 8'h04; exp_src2 = 8'h08; exp_rd = 8'h0C; exp_terr = 1'b0;
        exp_perf = PERF ? 16'd10 : 16'd0;

        // Watchdog, coincident ack, SETUP abort.
        do_op(0, 0, 10'h3FC, 10'h004, 10'h1F0);
        chk("timeout_sticky", 32'(timeout_err), 1);
        do_op(0, int'(TIMEOUT), 10'h044, 10'h088, 10'h0CC);
        do_op(0, 0, 10'h100, 10'h200, 10'h300);
        do_op(1, 0, 10'h014, 10'h028, 10'h03C);
        do_op(int'(SETUP_CYC), 0, 10'h018, 10'h02C, 10'h040);
        do_op(0, 1, 10'h3FF, 10'h3FE, 10'h3FD);

        // Reset mid-RUN aborts at once; held request does not relaunch.
        step();
        en = 1'b1; mat_a = 10'h050; mat_b = 10'h060; mat_c = 10'h070; ack = 1'b0;
        repeat (int'(SETUP_CYC) + 2) step();
        #1;
        chk("prerst_npu_en", 32'(npu_en), 1);
        #2;
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h1234; npu_addr = 32'h5678;
        rst = 1'b1;
        #1;
        chk("rst_async_npu_en", 32'(npu_en), 0);
        chk("rst_async_mem_addr", mem_addr, 32'h1234);
        chk("rst_async_stall", 32'(cpu_stall), 0);
        chk("rst_async_busy", 32'(busy), 0);
        exp_src1 = '0; exp_src2 = '0; exp_rd = '0; exp_terr = 1'b0; exp_perf = '0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            chk("held_busy", 32'(busy), 0);
            chk("held_npu_en", 32'(npu_en), 0);
            chk_regs();
        end
        step(); en = 1'b0;

        // Randomized operations.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_op($urandom_range(1, SETUP_CYC), 0,
                      10'($urandom), 10'($urandom), 10'($urandom));
            end else begin
                do_op(0, $urandom_range(0, TIMEOUT),
                      10'($urandom), 10'($urandom), 10'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/npu_launch_ctrl.md
Name: npu_launch_ctrl

Overview:
- Sequences one NPU operation per CPU request and arbitrates the single shared data-memory port between the CPU and the NPU.
- Latches the matrix addresses and waits a programmable setup delay before enabling the NPU.
- While the NPU runs, it owns the memory port and stalls CPU memory accesses. Completion comes from NPU ack or a watchdog timeout.
- Sits between TOPCPU and npu; replaces the ad-hoc 3-flop enable delay chain.

Parameters:
- SETUP_CYC, 3, cycles from accepted request to npu_en assertion (1..15)
- TIMEOUT, 1023, max RUN cycles before forced completion (1..65535)
- DW, 32, memory address/data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- cpu_en_npu  in  1  level request from CPU
- mat_a / mat_b / mat_c  in  10 each  byte addresses of src1, src2 and dest matrices
- npu_ack  in  1  NPU completion pulse
- cpu_mem_rd / cpu_mem_wr  in  1 each  CPU memory strobes
- cpu_addr / cpu_wd  in  DW each  CPU address and write data
- npu_mem_rd / npu_mem_wr  in  1 each  NPU memory strobes
- npu_addr / npu_wd  in  DW each  NPU address and write data
- mem_rd / mem_wr  out  1 each  muxed strobes to shared memory
- mem_addr / mem_wd  out  DW each  muxed address and write data
- npu_en  out  1  NPU enable, registered
- src1_addr / src2_addr / rd_addr  out  8 each  word addresses (mat_x[9:2]), registered
- cpu_stall  out  1  CPU memory hazard, combinational
- cpu_done  out  1  one-cycle completion pulse to CPU
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky watchdog flag
- perf_cycles  out  16  see Optional Feature

Behaviour:
- Reset values: npu_en=0, src*/rd_addr=0, cpu_done=0, busy=0, timeout_err=0, perf_cycles=0, owner=CPU, state=IDLE, counters=0.
- Reset asserted mid-operation aborts at once: npu_en drops asynchronously and ownership returns to CPU.
- Request detection uses a registered copy req_q of cpu_en_npu. A request is accepted on cpu_en_npu=1 && req_q=0 while in IDLE.
- IDLE:
  - On accept: latch mat_a[9:2], mat_b[9:2], mat_c[9:2] into the address outputs; load cnt=SETUP_CYC-1; go to SETUP.
  - A level held high from a previous op never re-triggers.
- SETUP:
  - Owner=CPU. Decrement cnt each cycle.
  - At cnt==0: go to RUN, set npu_en=1 and owner=NPU in the same edge. npu_en therefore first appears SETUP_CYC cycles after the accept edge.
  - If cpu_en_npu drops during SETUP: go to IDLE with no npu_en and no cpu_done.
- RUN:
  - npu_en=1, owner=NPU, watchdog wd counts up from 0. cpu_en_npu is ignored.
  - On npu_ack: go to DONE.
  - Else when wd==TIMEOUT-1: set timeout_err=1 and go to DONE.
  - If npu_ack and the timeout occur in the same cycle, ack wins and timeout_err is not set.
- DONE (one cycle): npu_en=0, owner=CPU, cpu_done=1. Then go to RELEASE.
- RELEASE: wait until cpu_en_npu=0, then go to IDLE. busy stays high.
- Mux:
  - owner=CPU: mem_* = cpu_*.
  - owner=NPU: mem_* = npu_*.
  - Non-owner strobes never reach memory.
- cpu_stall = owner==NPU && (cpu_mem_rd || cpu_mem_wr). It is combinational, zero latency, and deasserts in DONE.
- timeout_err clears only on rst or on the next accepted request.
- npu_ack outside RUN is ignored.
- Counter widths are sized to their parameters; wd never wraps.

Optional Feature:
- Macro: NPU_LAUNCH_PERF_EN.
- Defined: a 16-bit counter clears on RUN entry and increments each RUN cycle, saturating at 0xFFFF. On DONE entry it is copied to perf_cycles, which holds until the next DONE. A timeout reports TIMEOUT when TIMEOUT≤0xFFFF.
- Undefined: no counter logic; perf_cycles is tied to 0.

Test Plan:
- Reset, then cpu_en_npu 0→1 with mat_a=0x010, mat_b=0x020, mat_c=0x030 -> src1/src2/rd = 0x04/0x08/0x0C; npu_en rises exactly 3 cycles after the accept edge (SETUP_CYC=3).
- In RUN, drive npu_ack after 10 cycles -> cpu_done pulses for 1 cycle, npu_en falls on the same edge, ownership returns to CPU, busy stays high until cpu_en_npu=0, then IDLE. With the macro, perf_cycles=10.
- In RUN, CPU asserts cpu_mem_wr with cpu_addr=0x100 while NPU reads npu_addr=0x200 -> cpu_stall=1, mem_addr=0x200, mem_wr=0. After DONE, mem_addr=0x100 and mem_wr=1.
- TIMEOUT=16, no ack -> timeout_err=1 after 16 RUN cycles, cpu_done pulses. Ack coincident with the last cycle -> timeout_err stays 0.
- Drop cpu_en_npu during SETUP cycle 1 -> return to IDLE; npu_en and cpu_done never assert.
- Assert rst mid-RUN -> npu_en=0 and owner=CPU immediately. Holding cpu_en_npu high after reset release does not start a new operation until it toggles low→high.
